// File: rtl/regfile_mp.sv
// Multi-read-port register file with byte-enable writes, optional hardwired
// zero register, optional write-to-read bypass and a sequential sweep-clear.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   rd_addr   NUM_RD packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rd_data   NUM_RD packed registered read data, port k at [k*DATA_W +: DATA_W]
//   wr_en     write strobe
//   wr_addr   write address
//   wr_data   write data
//   wr_be     byte enables, bit j gates wr_data[8j+7:8j]
//   clr_req   pulse that starts a sweep clear
//   clr_busy  high while the sweep clear runs (exactly DEPTH cycles)
//   wr_drop   one-cycle pulse after a write ignored during a sweep
module regfile_mp #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic [DATA_W/8-1:0]        wr_be,
  input  logic                       clr_req,
  output logic                       clr_busy,
  output logic                       wr_drop
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned NB    = DATA_W / 8;

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                wr_drop_q;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                wr_zero;
  logic                wr_accept;
  logic [DATA_W-1:0]   wr_old;
  logic [DATA_W-1:0]   wr_merged;

  assign wr_zero   = (ZERO_REG != 0) && (wr_addr == '0);
  assign wr_accept = wr_en && (state_q == StIdle) && !wr_zero;
  assign wr_old    = mem_q[wr_addr];

  // New bytes where enabled, existing array bytes elsewhere.
  always_comb begin
    wr_merged = wr_old;
    for (int j = 0; j < NB; j++) begin
      if (wr_be[j]) wr_merged[8*j +: 8] = wr_data[8*j +: 8];
    end
  end

  // Sweep-clear FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (clr_req) begin
          state_d = StClear;
          cnt_d   = '0;
        end
      end
      StClear: begin
        cnt_d = cnt_q + ADDR_W'(1);
        // All-ones counter is the last entry; clr_req here is ignored.
        if (cnt_q == '1) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign clr_busy = (state_q == StClear);

  // Storage: the sweep owns the write port while clearing.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (state_q == StClear) begin
      mem_q[cnt_q] <= '0;
    end else if (wr_accept) begin
      mem_q[wr_addr] <= wr_merged;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) wr_drop_q <= 1'b0;
    else     wr_drop_q <= wr_en && (state_q == StClear);
  end

  assign wr_drop = wr_drop_q;

  // Read ports
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] rd_d;
    logic [DATA_W-1:0] rd_q;

    assign a = rd_addr[k*ADDR_W +: ADDR_W];

    always_comb begin
      rd_d = mem_q[a];
      if ((BYPASS != 0) && wr_accept && (wr_addr == a)) rd_d = wr_merged;
      if ((ZERO_REG != 0) && (a == '0)) rd_d = '0;
    end

    always_ff @(posedge clk) begin
      if (rst) rd_q <= '0;
      else     rd_q <= rd_d;
    end

    assign rd_data[k*DATA_W +: DATA_W] = rd_q;
  end

endmodule
